bf_code_loader: RTL

Upstream stage of brainfuckCore. Accepts a host byte stream (e.g. from a UART receiver) over a valid/ready handshake and discards non-command characters. Writes the surviving command bytes sequentially into the code memory, then appends a terminator byte. Holds the core in reset while loading and releases it once a complete, well-formed program is stored.

---
 rtl/bf_pkg.sv | 36 +++
 rtl/bf_bracket_checker.sv | 55 +++++
 rtl/bf_code_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the brainfuck code loader:
//   - state_t     : loader FSM states
//   - CH_*        : command character codes
//   - is_bf_cmd() : returns 1 when a byte is one of the eight commands
// -----------------------------------------------------------------------------
package bf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TERM  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [7:0] CH_INC   = 8'h2B; // '+'
    localparam logic [7:0] CH_IN    = 8'h2C; // ','
    localparam logic [7:0] CH_DEC   = 8'h2D; // '-'
    localparam logic [7:0] CH_OUT   = 8'h2E; // '.'
    localparam logic [7:0] CH_LEFT  = 8'h3C; // '<'
    localparam logic [7:0] CH_RIGHT = 8'h3E; // '>'
    localparam logic [7:0] CH_OPEN  = 8'h5B; // '['
    localparam logic [7:0] CH_CLOSE = 8'h5D; // ']'

    function automatic logic is_bf_cmd(input logic [7:0] b);
        case (b)
            CH_INC, CH_IN, CH_DEC, CH_OUT,
            CH_LEFT, CH_RIGHT, CH_OPEN, CH_CLOSE: is_bf_cmd = 1'b1;
            default:                              is_bf_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bf_bracket_checker.sv
// -----------------------------------------------------------------------------
// bf_bracket_checker
// Tracks '[' / ']' nesting of the bytes written by the loader and raises a
// sticky error flag on an unmatched ']', on a non-zero depth at end of load,
// or on nesting deeper than the counter can hold.
// Only compiled and instantiated when BF_LOADER_BRACKET_CHECK_EN is defined.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   clear       start of a new load: depth and error return to 0
//   cmd_accept  a command byte is being stored this cycle
//   cmd_byte    the command byte being stored
//   end_accept  the end-of-load character is being accepted this cycle
//   error       sticky bracket error for the current load
// -----------------------------------------------------------------------------
`ifdef BF_LOADER_BRACKET_CHECK_EN
module bf_bracket_checker
    import bf_pkg::*;
#(
    parameter int MAX_DEPTH_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       cmd_accept,
    input  logic [7:0] cmd_byte,
    input  logic       end_accept,
    output logic       error
);

    logic [MAX_DEPTH_W-1:0] depth;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
            error <= 1'b0;
        end else if (clear) begin
            depth <= '0;
            error <= 1'b0;
        end else begin
            if (cmd_accept && cmd_byte == CH_OPEN) begin
                // Saturate instead of wrapping so a later ']' cannot mask it.
                if (depth == '1) error <= 1'b1;
                else             depth <= depth + 1'b1;
            end else if (cmd_accept && cmd_byte == CH_CLOSE) begin
                if (depth == '0) error <= 1'b1;
                else             depth <= depth - 1'b1;
            end
            if (end_accept && depth != '0) error <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/bf_code_loader.sv
// -----------------------------------------------------------------------------
// bf_code_loader
// Upstream stage of brainfuckCore. Accepts host bytes over valid/ready, drops
// non-command characters, writes commands sequentially into code memory,
// appends TERM_BYTE, and releases the core from reset once the program is
// stored. start_load restarts a load from any state.
//
// Optional feature (compile-time macro): BF_LOADER_BRACKET_CHECK_EN
//   defined   : bracket nesting is checked; a mismatch ends the load in ERROR
//   undefined : no bracket logic; only address overflow leads to ERROR
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   start_load    single-cycle pulse, begins a new load
//   rx_data       host byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte (high only in LOAD)
//   code_wr_addr  code memory write address
//   code_wr_data  code memory write data
//   code_wr_en    code memory write strobe
//   core_reset    active-low reset to the core; high only in RUN
//   load_done     high in RUN
//   load_error    high in ERROR
//   program_len   command bytes stored by the last load
// -----------------------------------------------------------------------------
module bf_code_loader
    import bf_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 9,
    parameter logic [7:0] TERM_BYTE   = 8'h00,
    parameter logic [7:0] END_CHAR    = 8'h21,
    parameter int         MAX_DEPTH_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] code_wr_addr,
    output logic [7:0]            code_wr_data,
    output logic                  code_wr_en,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] program_len
);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  cmd_accept;
    logic                  end_accept;
    logic                  addr_full;
    logic                  bracket_err;

    // rx_ready is a registered copy of "state == LOAD", so a handshake can
    // only complete while loading.
    assign accept     = rx_valid && rx_ready;
    assign cmd_accept = accept && is_bf_cmd(rx_data);
    assign end_accept = accept && (rx_data == END_CHAR);
    // The top slot is kept free for the terminator.
    assign addr_full  = (addr == '1);

    assign program_len = addr;

`ifdef BF_LOADER_BRACKET_CHECK_EN
    bf_bracket_checker #(
        .MAX_DEPTH_W (MAX_DEPTH_W)
    ) u_bracket_checker (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .cmd_accept (cmd_accept && !addr_full && !start_load),
        .cmd_byte   (rx_data),
        .end_accept (end_accept && !start_load),
        .error      (bracket_err)
    );
`else
    assign bracket_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: ;
            ST_LOAD: begin
                if (cmd_accept && addr_full) next_state = ST_ERROR;
                else if (end_accept)         next_state = ST_TERM;
            end
            ST_TERM:  next_state = ST_CHECK;
            ST_CHECK: next_state = bracket_err ? ST_ERROR : ST_RUN;
            ST_RUN:   ;
            ST_ERROR: ;
            default:  next_state = ST_IDLE;
        endcase
        if (start_load) next_state = ST_LOAD;
    end

    // Control outputs are decoded from next_state and registered, so they
    // change exactly on the edge that enters the corresponding state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready   <= 1'b0;
            core_reset <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            rx_ready   <= (next_state == ST_LOAD);
            core_reset <= (next_state == ST_RUN);
            load_done  <= (next_state == ST_RUN);
            load_error <= (next_state == ST_ERROR);
        end
    end

    // Write port and address counter. A write shows up the cycle after the
    // byte is accepted; the address advances on that same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr         <= '0;
            code_wr_en   <= 1'b0;
            code_wr_addr <= '0;
            code_wr_data <= '0;
        end else begin
            code_wr_en <= 1'b0;
            if (start_load) begin
                addr <= '0;
            end else if (cmd_accept && !addr_full) begin
                code_wr_en   <= 1'b1;
                code_wr_addr <= addr;
                code_wr_data <= rx_data;
                addr         <= addr + 1'b1;
            end else if (state == ST_TERM) begin
                // Terminator does not count toward program_len.
                code_wr_en   <= 1'b1;
                code_wr_addr <= addr;
                code_wr_data <= TERM_BYTE;
            end
        end
    end

endmodule
